// File: rtl/s2p_if.sv
// Serial link bundle for the s2p receiver: four source-driven link signals plus the parallel result.
// The master side drives the link; the slave side is the receiver.
interface s2p_if #(
  parameter int WIDTH = 16,
  parameter int ERRW  = 8
);
  logic             sclk;
  logic             sdin;
  logic             sen;
  logic             sclr;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             frame_err;
  logic [ERRW-1:0]  err_count;
  logic             busy;

  modport master (
    output sclk, sdin, sen, sclr,
    input  data, valid, frame_err, err_count, busy
  );

  modport slave (
    input  sclk, sdin, sen, sclr,
    output data, valid, frame_err, err_count, busy
  );
endinterface

// File: rtl/s2p.sv
// Serial-to-parallel receiver for the display/LED link: synchronises the link, counts bits per frame
// and publishes good frames as a parallel word with a one-cycle valid strobe.
//   state | meaning
//   IDLE  | waiting for sen to fall; sclk edges ignored
//   SHIFT | frame open; each sclk rise shifts one bit in, sen rise closes and judges the frame
module s2p #(
  parameter int WIDTH = 16,
  parameter int ERRW  = 8
) (
  input  logic  clk,
  input  logic  rst,
  s2p_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic r_sclk_meta, r_sclk_sync, r_sclk_hist;
  logic r_sdin_meta, r_sdin_sync, r_sdin_hist;
  logic r_sen_meta,  r_sen_sync,  r_sen_hist;
  logic r_sclr_meta, r_sclr_sync, r_sclr_hist;

  logic r_sclk_rise;
  logic r_sen_rise;
  logic r_sen_fall;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_load;
  logic             w_err;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic [ERRW-1:0]  r_err_count;

  // Idle levels on reset keep sen/sclr from producing a spurious edge when reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_hist <= 1'b0;
      r_sdin_meta <= 1'b0;
      r_sdin_sync <= 1'b0;
      r_sdin_hist <= 1'b0;
      r_sen_meta  <= 1'b1;
      r_sen_sync  <= 1'b1;
      r_sen_hist  <= 1'b1;
      r_sclr_meta <= 1'b1;
      r_sclr_sync <= 1'b1;
      r_sclr_hist <= 1'b1;
    end else begin
      r_sclk_meta <= bus.sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_hist <= r_sclk_sync;
      r_sdin_meta <= bus.sdin;
      r_sdin_sync <= r_sdin_meta;
      r_sdin_hist <= r_sdin_sync;
      r_sen_meta  <= bus.sen;
      r_sen_sync  <= r_sen_meta;
      r_sen_hist  <= r_sen_sync;
      r_sclr_meta <= bus.sclr;
      r_sclr_sync <= r_sclr_meta;
      r_sclr_hist <= r_sclr_sync;
    end
  end

  // Edge strobes are registered alongside the history stage, so the sdin and sclr history bits
  // line up with the strobes in the cycle the FSM consumes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_rise <= 1'b0;
      r_sen_rise  <= 1'b0;
      r_sen_fall  <= 1'b0;
    end else begin
      r_sclk_rise <= r_sclk_sync & ~r_sclk_hist;
      r_sen_rise  <= r_sen_sync & ~r_sen_hist;
      r_sen_fall  <= ~r_sen_sync & r_sen_hist;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_err       = 1'b0;
    if (!r_sclr_hist) begin
      w_state_nxt = IDLE;
      w_shreg_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_sen_fall) begin
            w_state_nxt = SHIFT;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
        SHIFT: begin
          // A bit arriving together with the closing sen edge counts towards this frame.
          if (r_sclk_rise) begin
            w_shreg_nxt = {r_shreg[WIDTH-2:0], r_sdin_hist};
            w_cnt_nxt   = (r_cnt == CNT_SAT) ? CNT_SAT : r_cnt + CW'(1);
          end
          if (r_sen_rise) begin
            w_state_nxt = IDLE;
            if (w_cnt_nxt == CNT_FULL) begin
              w_load = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_valid     <= w_load;
      r_frame_err <= w_err;
      if (w_load) begin
        r_data <= w_shreg_nxt;
      end
      if (w_err && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + ERRW'(1);
      end
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.err_count = r_err_count;
  assign bus.busy      = (r_state == SHIFT);

endmodule
